// File: rtl/line_memory_responder.sv
// line_memory_responder: main-memory side of the cache line-transfer interface.
// Accepts one line request at a time, waits LATENCY cycles, then streams a fill
// (rd_valid/rd_data/beat_offset) or absorbs a writeback (wr_ready/wr_data),
// and pulses done for one cycle afterwards.
// Ports: clk/reset (async, active-high); req_valid/req_write/req_addr/req_ready
// request handshake; wr_data/wr_ready writeback beats; rd_valid/rd_data fill
// beats; beat_offset byte offset of the current beat; done end-of-request pulse.
module line_memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LINE_WIDTH = 4,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic [31:0]           wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [31:0]           rd_data,
  output logic [LINE_WIDTH-1:0] beat_offset,
  output logic                  done
);

  localparam int BW    = LINE_WIDTH - 2;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_LOAD = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
  localparam logic [BW-1:0] LAST_BEAT = '1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RBURST, S_WBURST, S_DONE} state_t;

  state_t                   state, nxt;
  logic [BW-1:0]            beat;
  logic [CW-1:0]            lat_cnt;
  logic [ADDR_WIDTH-BW-1:0] base;
  logic                     is_write;
  logic                     accept;
  logic [ADDR_WIDTH-1:0]    word_addr;
  logic [31:0]              mem [DEPTH];

  // Offset bits and bits above the store are dropped: lines are force-aligned
  // and addresses alias modulo the store size.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[LINE_WIDTH-1:0]};

  assign accept    = req_valid & req_ready;
  assign word_addr = {base, beat};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY > 0)    nxt = S_WAIT;
          else if (req_write) nxt = S_WBURST;
          else                nxt = S_RBURST;
        end
      end
      S_WAIT:   if (lat_cnt == '0) nxt = is_write ? S_WBURST : S_RBURST;
      S_RBURST: if (beat == LAST_BEAT) nxt = S_DONE;
      S_WBURST: if (beat == LAST_BEAT) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    beat_offset = '0;
    done        = 1'b0;
    case (state)
      S_IDLE: req_ready = 1'b1;
      S_RBURST: begin
        rd_valid    = 1'b1;
        rd_data     = mem[word_addr];
        beat_offset = {beat, 2'b00};
      end
      S_WBURST: begin
        wr_ready    = 1'b1;
        beat_offset = {beat, 2'b00};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Request context and counters. beat wraps back to 0 after the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat     <= '0;
      lat_cnt  <= '0;
      base     <= '0;
      is_write <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            base     <= req_addr[ADDR_WIDTH+1:LINE_WIDTH];
            is_write <= req_write;
            lat_cnt  <= LAT_LOAD;
            beat     <= '0;
          end
        end
        S_WAIT:   if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        S_RBURST: beat <= beat + 1'b1;
        S_WBURST: beat <= beat + 1'b1;
        default: ;
      endcase
    end
  end

  // Backing store: never reset. Reset forces IDLE asynchronously, so an edge
  // seen while reset is high cannot write a dropped beat.
  always_ff @(posedge clk) begin
    if (state == S_WBURST) mem[word_addr] <= wr_data;
  end

endmodule

// File: tb/tb_line_memory_responder.sv
module tb_line_memory_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance a: default parameters (LATENCY=3)
  logic        a_req_valid, a_req_write, a_req_ready, a_wr_ready, a_rd_valid, a_done;
  logic [31:0] a_req_addr, a_wr_data, a_rd_data;
  logic [3:0]  a_beat_offset;
  // Instance z: LATENCY=0
  logic        z_req_valid, z_req_write, z_req_ready, z_wr_ready, z_rd_valid, z_done;
  logic [31:0] z_req_addr, z_wr_data, z_rd_data;
  logic [3:0]  z_beat_offset;

  int n_cmp = 0;
  int n_err = 0;

  line_memory_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
    .req_ready(a_req_ready), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .beat_offset(a_beat_offset),
    .done(a_done)
  );

  line_memory_responder #(.ADDR_WIDTH(10), .LINE_WIDTH(4), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_write(z_req_write), .req_addr(z_req_addr),
    .req_ready(z_req_ready), .wr_data(z_wr_data), .wr_ready(z_wr_ready),
    .rd_valid(z_rd_valid), .rd_data(z_rd_data), .beat_offset(z_beat_offset),
    .done(z_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Writeback of four words on instance a, driving wr_data on each wr_ready cycle.
  task automatic a_wb(input logic [31:0] addr, input logic [127:0] d);
    int n = 0;
    bit seen = 0;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = addr;
    tick;
    a_req_valid = 1'b0; a_req_write = 1'b0;
    for (int k = 0; k < 32 && !seen; k++) begin
      if (a_wr_ready && n < 4) begin
        a_wr_data = d[32*n +: 32];
        n++;
      end
      if (a_done) seen = 1;
      else tick;
    end
    n_cmp++;
    if (!seen || n != 4) begin
      n_err++;
      $display("FAIL wb_handshake addr=%h: beats=%0d done_seen=%b, required beats=4 done_seen=1", addr, n, seen);
    end
    a_wr_data = '0;
    tick;
  endtask

  // Fill on instance a, collecting the beats; returns beat count.
  task automatic a_fill(input logic [31:0] addr, output logic [127:0] got, output int nb);
    bit seen = 0;
    got = '0;
    nb = 0;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = addr;
    tick;
    a_req_valid = 1'b0;
    for (int k = 0; k < 32 && !seen; k++) begin
      if (a_rd_valid && nb < 4) begin
        got[32*nb +: 32] = a_rd_data;
        nb++;
      end
      if (a_done) seen = 1;
      else tick;
    end
    if (!seen) nb = -1;
    tick;
  endtask

  task automatic test_reset;
    n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", a_req_ready); end
    n_cmp++; if (a_wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b want 0", a_wr_ready); end
    n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", a_rd_valid); end
    n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", a_done); end
    n_cmp++; if (a_rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", a_rd_data); end
    n_cmp++; if (a_beat_offset !== 4'h0) begin n_err++; $display("FAIL reset_beat_offset: got %h want 0", a_beat_offset); end
    n_cmp++; if (z_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_z_req_ready: got %b want 1", z_req_ready); end
  endtask

  // Preload words 0x40..0x43 and fill from 0x100; cycle k = k edges after acceptance.
  task automatic test_fill;
    logic [127:0] pre;
    logic         ev;
    logic [31:0]  ed;
    logic [3:0]   eo;
    pre = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    a_wb(32'h100, pre);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h100;
    tick;
    a_req_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      ev = (k >= 4 && k <= 7);
      ed = ev ? 32'hA0 + 32'(k - 4) : 32'h0;
      eo = ev ? 4'((k - 4) * 4) : 4'h0;
      n_cmp++; if (a_rd_valid !== ev) begin n_err++; $display("FAIL fill_rd_valid c%0d: got %b want %b", k, a_rd_valid, ev); end
      n_cmp++; if (a_rd_data !== ed) begin n_err++; $display("FAIL fill_rd_data c%0d: got %h want %h", k, a_rd_data, ed); end
      n_cmp++; if (a_beat_offset !== eo) begin n_err++; $display("FAIL fill_beat_offset c%0d: got %h want %h", k, a_beat_offset, eo); end
      n_cmp++; if (a_done !== (k == 8)) begin n_err++; $display("FAIL fill_done c%0d: got %b want %b", k, a_done, (k == 8)); end
      n_cmp++; if (a_req_ready !== (k == 9)) begin n_err++; $display("FAIL fill_req_ready c%0d: got %b want %b", k, a_req_ready, (k == 9)); end
      if (k < 9) tick;
    end
  endtask

  // 0x208 is unaligned: the line lands at words 0x80..0x83.
  task automatic test_writeback_unaligned;
    logic [127:0] d, got;
    int nb;
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    a_wb(32'h208, d);
    a_fill(32'h200, got, nb);
    n_cmp++; if (nb !== 4) begin n_err++; $display("FAIL wb_unaligned_beats: got %0d want 4", nb); end
    n_cmp++; if (got !== d) begin n_err++; $display("FAIL wb_unaligned_data: got %h want %h", got, d); end
  endtask

  task automatic test_latency0;
    logic [31:0] e;
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h0;
    tick;
    z_req_valid = 1'b0; z_req_write = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      z_wr_data = (k >= 1 && k <= 4) ? 32'hE0 + 32'(k - 1) : 32'h0;
      n_cmp++; if (z_wr_ready !== (k <= 4)) begin n_err++; $display("FAIL lat0_wr_ready c%0d: got %b want %b", k, z_wr_ready, (k <= 4)); end
      n_cmp++; if (z_done !== (k == 5)) begin n_err++; $display("FAIL lat0_wb_done c%0d: got %b want %b", k, z_done, (k == 5)); end
      if (k < 6) tick;
    end
    z_wr_data = 32'h0;
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h0;
    tick;
    z_req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      e = (k <= 4) ? 32'hE0 + 32'(k - 1) : 32'h0;
      n_cmp++; if (z_rd_valid !== (k <= 4)) begin n_err++; $display("FAIL lat0_rd_valid c%0d: got %b want %b", k, z_rd_valid, (k <= 4)); end
      n_cmp++; if (z_rd_data !== e) begin n_err++; $display("FAIL lat0_rd_data c%0d: got %h want %h", k, z_rd_data, e); end
      n_cmp++; if (z_done !== (k == 5)) begin n_err++; $display("FAIL lat0_fill_done c%0d: got %b want %b", k, z_done, (k == 5)); end
      n_cmp++; if (z_req_ready !== (k == 6)) begin n_err++; $display("FAIL lat0_req_ready c%0d: got %b want %b", k, z_req_ready, (k == 6)); end
      if (k < 6) tick;
    end
  endtask

  // 0x1010 aliases 0x10 with a 1024-word store.
  task automatic test_alias;
    logic [127:0] d, got;
    int nb;
    d = {32'h5A5A0004, 32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001};
    a_wb(32'h1010, d);
    a_fill(32'h10, got, nb);
    n_cmp++; if (nb !== 4) begin n_err++; $display("FAIL alias_beats: got %0d want 4", nb); end
    n_cmp++; if (got !== d) begin n_err++; $display("FAIL alias_data: got %h want %h", got, d); end
  endtask

  task automatic test_reset_mid_wb;
    logic [127:0] old_d, new_d, exp_d, got;
    int n = 0;
    int nb;
    bit hit = 0;
    old_d = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    new_d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    exp_d = {32'hC3, 32'hC2, 32'hD1, 32'hD0};
    a_wb(32'h300, old_d);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h300;
    tick;
    a_req_valid = 1'b0; a_req_write = 1'b0;
    for (int k = 0; k < 32 && !hit; k++) begin
      if (a_wr_ready) begin
        if (n == 2) hit = 1;
        else begin
          a_wr_data = new_d[32*n +: 32];
          n++;
        end
      end
      if (!hit) tick;
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL rst_mid_reach_beat2: got 0 want 1"); end
    a_wr_data = new_d[64 +: 32];
    reset = 1'b1;
    #1;
    n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_req_ready: got %b want 1", a_req_ready); end
    n_cmp++; if (a_wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_wr_ready: got %b want 0", a_wr_ready); end
    n_cmp++; if (a_beat_offset !== 4'h0) begin n_err++; $display("FAIL rst_mid_beat_offset: got %h want 0", a_beat_offset); end
    n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", a_done); end
    tick;
    tick;
    reset = 1'b0;
    a_wr_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_done c%0d: got %b want 0", k, a_done); end
      n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready_after c%0d: got %b want 1", k, a_req_ready); end
      tick;
    end
    a_fill(32'h300, got, nb);
    n_cmp++; if (nb !== 4) begin n_err++; $display("FAIL rst_mid_fill_beats: got %0d want 4", nb); end
    n_cmp++; if (got !== exp_d) begin n_err++; $display("FAIL rst_mid_partial: got %h want %h", got, exp_d); end
  endtask

  // req_valid held through 18 cycles: accepts at cycles 0 and 9, done at 8 and 17.
  task automatic test_hold_valid;
    int acc = 0;
    int dn = 0;
    int second = -1;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h100;
    for (int c = 0; c < 18; c++) begin
      if (a_req_ready) begin
        acc++;
        if (acc == 2) second = c;
      end
      if (a_done) dn++;
      tick;
    end
    a_req_valid = 1'b0;
    n_cmp++; if (acc !== 2) begin n_err++; $display("FAIL hold_accepts: got %0d want 2", acc); end
    n_cmp++; if (dn !== 2) begin n_err++; $display("FAIL hold_dones: got %0d want 2", dn); end
    n_cmp++; if (second !== 9) begin n_err++; $display("FAIL hold_second_accept_cycle: got %0d want 9", second); end
    n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL hold_idle_after: got %b want 1", a_req_ready); end
    tick;
  endtask

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_wr_data = '0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_wr_data = '0;
    #1;
    test_reset;
    tick;
    tick;
    reset = 1'b0;
    tick;
    test_fill;
    test_writeback_unaligned;
    test_latency0;
    test_alias;
    test_reset_mid_wb;
    test_hold_valid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/line_memory_responder.md
Name: line_memory_responder

Overview:
- Main-memory side of the cache line-transfer interface.
- Accepts one line request at a time from a cache controller:
  - fill (read): streams the line out word by word;
  - writeback (write): absorbs the line word by word.
- Inserts a configurable access latency before each burst, so cache FSMs can be exercised against a non-ideal memory.
- Holds the word-addressed backing store internally.

Parameters:
- ADDR_WIDTH, 10, log2 of backing-store depth in 32-bit words.
- LINE_WIDTH, 4, log2 of line size in bytes; beats per line BEATS = 2**(LINE_WIDTH-2).
- LATENCY, 3, idle cycles between request acceptance and the first beat; 0 allowed.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = writeback, 0 = fill; sampled at acceptance.
- req_addr  input  32  byte address of the line.
- req_ready  output  1  high only in IDLE; acceptance = req_valid & req_ready.
- wr_data  input  32  writeback beat data; must be valid whenever wr_ready is high.
- wr_ready  output  1  a writeback beat is consumed this cycle.
- rd_valid  output  1  a fill beat is presented this cycle.
- rd_data  output  32  fill beat word; 0 when rd_valid is low.
- beat_offset  output  LINE_WIDTH  byte offset of the current beat within the line (beat << 2); 0 outside bursts.
- done  output  1  one-cycle pulse after the last beat of any request.

Behaviour:
- Reset (async assert): state IDLE, beat counter 0, latency counter 0. Outputs: req_ready=1; wr_ready, rd_valid, done = 0; rd_data, beat_offset = 0. The backing store is NOT cleared.
- Address capture at acceptance:
  - base = req_addr[ADDR_WIDTH+1 : LINE_WIDTH]; line offset bits are ignored (forced alignment).
  - Bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo store size.
  - req_write is latched. Later changes to req_* have no effect until the next IDLE.
- States:
  - IDLE: req_ready=1. On acceptance, go to WAIT if LATENCY>0, else directly to RBURST/WBURST. The latency counter loads LATENCY-1.
  - WAIT: count down. When the counter is 0, go to RBURST (fill) or WBURST (writeback), beat=0.
  - RBURST: rd_valid=1 for exactly BEATS consecutive cycles. rd_data = store[{base, beat}], beat_offset = beat<<2, beat increments each cycle. No backpressure. After beat BEATS-1, go to DONE.
  - WBURST: wr_ready=1 for exactly BEATS consecutive cycles. At each rising edge, store[{base, beat}] <= wr_data, beat increments. After beat BEATS-1, go to DONE.
  - DONE: done=1, req_ready=0 for one cycle, then IDLE.
- Timing:
  - Acceptance at edge N gives the first beat in cycle N+1+LATENCY.
  - The last beat occurs LATENCY+BEATS cycles after acceptance; done follows in the next cycle.
  - Earliest next acceptance is the cycle after done.
- A read of a word written by an earlier writeback returns the new value; there is no overlap, because requests are serialized.
- Reset asserted mid-burst: immediately IDLE. Words already written in a partial writeback stay written; the remaining beats are dropped. A partial fill produces no done.
- req_valid held high through done: not re-accepted until IDLE (one request per handshake).

Test Plan:
- Defaults, preload store[0x40..0x43]=A0..A3; fill at req_addr=0x100 -> rd_valid in cycles 4–7 after acceptance, rd_data A0,A1,A2,A3, beat_offset 0,4,8,12, done in cycle 8.
- Writeback at 0x208 (unaligned) with wr_data 0x11,0x22,0x33,0x44 -> stored at words 0x80..0x83; following fill of 0x200 returns the same four words.
- LATENCY=0 fill at 0x0 -> rd_valid in the cycle after acceptance, done 5 cycles after acceptance, req_ready low throughout.
- Alias: writeback to 0x1000 + 0x10 (ADDR_WIDTH=10) -> fill at 0x10 returns the written data.
- Reset asserted during beat 2 of a writeback -> outputs immediately at reset values. Words 0 and 1 updated, words 2 and 3 unchanged, no done pulse. req_ready=1 after release.
- req_valid held high for 20 cycles -> exactly two acceptances for LATENCY=3, BEATS=4, each separated by a done pulse.
